painterengine_gpu_gpuinfo_dispatch: RTL and testbench
=====================================================

# painterengine_gpu_gpuinfo_dispatch

Host-side dispatcher sitting directly upstream of the GPU info unit. It accepts one command at a time on a valid/ready channel and drives the info unit's opcode. It waits for the unit to reach DONE or ERROR, or for a timeout, then returns status and data on a valid/ready response channel. After every command it re-arms the unit by pulsing the unit's active-low reset, because the unit holds DONE/ERROR until reset.

## Interface
- `TIMEOUT_CYCLES`, default 16: max cycles in ISSUE+WAIT before a TIMEOUT response; must be ≥ 4.
- `RESET_CYCLES`, default 2: cycles `o_wire_unit_resetn` is held low to re-arm the unit; must be ≥ 1.

Ports:
- `i_wire_clock`  in  1: the single clock.
- `i_wire_resetn`  in  1: reset, synchronous, active-low.
- `i_wire_cmd_valid`  in  1: command present.
- `o_wire_cmd_ready`  out  1: dispatcher can accept a command.
- `i_wire_cmd_opcode`  in  32: opcode to execute.
- `o_wire_rsp_valid`  out  1: response present.
- `i_wire_rsp_ready`  in  1: host accepts response.
- `o_wire_rsp_status`  out  2: 0 OK, 1 UNIT_ERROR, 2 TIMEOUT, 3 BADOP.
- `o_wire_rsp_data`  out  32: unit return value; 0 unless status is OK.
- `o_wire_unit_resetn`  out  1: active-low reset to the info unit.
- `o_wire_unit_opcode`  out  32: opcode to the info unit.
- `i_wire_unit_state`  in  32: unit state: 0 IDLE, 1 PROCESSING, 2 ERROR, 3 DONE.
- `i_wire_unit_return`  in  32: unit return value.

## Operation
- All outputs are registered.
- Reset value of every output is 0, including `o_wire_unit_resetn`, so the unit is held in reset.
- After `i_wire_resetn` deasserts, the FSM enters REARM.

FSM states:
- **REARM**
  - `unit_resetn` = 0 and `unit_opcode` = 0.
  - Counts `RESET_CYCLES` cycles, then goes to IDLE, setting `unit_resetn` = 1 and `cmd_ready` = 1.
- **IDLE**
  - `cmd_ready` = 1.
  - On `cmd_valid & cmd_ready` with opcode == 0: go to RESP with status BADOP, data 0. The unit is not touched.
  - On `cmd_valid & cmd_ready` with opcode ≠ 0: go to ISSUE, set `unit_opcode` = opcode, clear the timeout counter, and set `cmd_ready` = 0.
- **ISSUE**
  - Holds `unit_opcode` until `unit_state` ≠ IDLE.
  - If `unit_state` is PROCESSING: go to WAIT and set `unit_opcode` = 0.
  - If `unit_state` is DONE or ERROR: go directly to RESP.
- **WAIT**
  - `unit_state` == DONE: RESP with status OK, data = `unit_return`.
  - `unit_state` == ERROR: RESP with status UNIT_ERROR, data 0.
  - Other states (including undefined state values, treated as still busy): remain in WAIT.
- **Timeout**
  - The counter increments every cycle in ISSUE or WAIT.
  - On the cycle where the counter equals `TIMEOUT_CYCLES-1` without a completion, go to RESP with status TIMEOUT, data 0.
  - If completion and timeout occur in the same cycle, completion wins.
- **RESP**
  - `rsp_valid` = 1. Status and data are stable until `rsp_valid & rsp_ready`.
  - On handshake: `rsp_valid` = 0 and go to REARM. REARM is entered even after BADOP, for uniformity.
- **Reset mid-operation**
  - Any `i_wire_resetn` low forces all outputs to 0 on the next edge.
  - Any pending command or response is dropped, and the FSM restarts via REARM.

## Timing
- Let command handshake be at edge E0 with a valid opcode and a well-behaved unit.
  - After E0: `unit_opcode` = op.
  - After E1: unit is PROCESSING.
  - After E2: unit is DONE/ERROR and the dispatcher is in WAIT with `unit_opcode` = 0.
  - After E3: `rsp_valid` = 1. Command-to-response latency is 3 cycles.
- BADOP: `rsp_valid` = 1 after E0 (1 cycle).
- Response handshake at edge R0:
  - `unit_resetn` = 0 for `RESET_CYCLES` cycles.
  - `cmd_ready` returns to 1 after edge R0+`RESET_CYCLES`+1.
- `rsp_ready` may be held low indefinitely. No timeout applies in RESP.
- `cmd_ready` is never 1 while `rsp_valid` = 1. There is one outstanding command maximum.

## Structure
- The shared package `painterengine_gpu_pkg` holds:
  - unit opcode constants (RESET 0, GETVERSION 1, GETDEBUG 2);
  - unit state constants (IDLE 0, PROCESSING 1, ERROR 2, DONE 3);
  - response status codes;
  - dispatcher FSM state encoding.
- One sub-module is natural: `painterengine_gpu_cycle_counter`. It is a loadable down-counter with a terminal flag, reused for the REARM length and for the timeout.

## Test plan
- GETVERSION: cmd opcode 1 with the real info unit attached. Required: `rsp_valid` 3 cycles after handshake, status 0, data 0x00000001, then `unit_resetn` low 2 cycles, then `cmd_ready` = 1.
- GETDEBUG: opcode 2. Required: status 0, data 0x20240612.
- Unknown opcode: opcode 5. Required: status 1, data 0, and the unit is re-armed (state back to 0) before the next `cmd_ready`.
- BADOP: opcode 0. Required: `rsp_valid` 1 cycle later, status 3, data 0, and `unit_opcode` stays 0 throughout.
- Timeout: stub unit holding state 1. Required: status 2, data 0, exactly 16 cycles after the handshake edge. A second run has the stub return DONE in the 16th cycle; required status 0.
- Backpressure and mid-op reset:
  - Hold `rsp_ready` = 0 for 10 cycles. Required: response stable and `cmd_ready` = 0.
  - Assert `i_wire_resetn` = 0 while in WAIT. Required: all outputs 0 next edge, and no response is emitted after release.

Source files
------------

// File: rtl/painterengine_gpu_pkg.sv
// Shared constants and types for the PainterEngine GPU info dispatcher.
// Unit opcodes/states mirror the info unit's 32-bit encoding.
package painterengine_gpu_pkg;

    localparam logic [31:0] OP_RESET      = 32'd0;
    localparam logic [31:0] OP_GETVERSION = 32'd1;
    localparam logic [31:0] OP_GETDEBUG   = 32'd2;

    localparam logic [31:0] UNIT_IDLE       = 32'd0;
    localparam logic [31:0] UNIT_PROCESSING = 32'd1;
    localparam logic [31:0] UNIT_ERROR      = 32'd2;
    localparam logic [31:0] UNIT_DONE       = 32'd3;

    typedef enum logic [1:0] {
        RSP_OK         = 2'd0,
        RSP_UNIT_ERROR = 2'd1,
        RSP_TIMEOUT    = 2'd2,
        RSP_BADOP      = 2'd3
    } rsp_status_e;

    typedef enum logic [2:0] {
        ST_REARM = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } disp_state_e;

endpackage

// File: rtl/painterengine_gpu_cycle_counter.sv
// Loadable down-counter with a terminal flag at zero.
// Used for both the re-arm pulse length and the command timeout.
module painterengine_gpu_cycle_counter #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             terminal
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= RESET_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    assign terminal = (count_q == '0);

endmodule

// File: rtl/painterengine_gpu_gpuinfo_dispatch.sv
// Host-side dispatcher for the GPU info unit: issues one opcode, waits for
// DONE/ERROR/timeout, returns a response, then re-arms the unit via its reset.
module painterengine_gpu_gpuinfo_dispatch
    import painterengine_gpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int RESET_CYCLES   = 2
) (
    input  logic        i_wire_clock,
    input  logic        i_wire_resetn,
    input  logic        i_wire_cmd_valid,
    output logic        o_wire_cmd_ready,
    input  logic [31:0] i_wire_cmd_opcode,
    output logic        o_wire_rsp_valid,
    input  logic        i_wire_rsp_ready,
    output logic [1:0]  o_wire_rsp_status,
    output logic [31:0] o_wire_rsp_data,
    output logic        o_wire_unit_resetn,
    output logic [31:0] o_wire_unit_opcode,
    input  logic [31:0] i_wire_unit_state,
    input  logic [31:0] i_wire_unit_return
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > RESET_CYCLES) ?
                             TIMEOUT_CYCLES : RESET_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] TO_LOAD = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] RA_LOAD = CW'(RESET_CYCLES);

    disp_state_e state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    rsp_status_e rsp_status_q, rsp_status_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        unit_resetn_q, unit_resetn_d;
    logic [31:0] unit_opcode_q, unit_opcode_d;

    logic          cnt_load;
    logic [CW-1:0] cnt_load_val;
    logic          cnt_dec;
    logic [CW-1:0] cnt_count;
    logic          cnt_term;

    logic unit_done;
    logic unit_err;

    painterengine_gpu_cycle_counter #(
        .WIDTH     (CW),
        .RESET_VAL (RA_LOAD)
    ) u_cnt (
        .clk      (i_wire_clock),
        .rst_n    (i_wire_resetn),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (cnt_count),
        .terminal (cnt_term)
    );

    assign unit_done = (i_wire_unit_state == UNIT_DONE);
    assign unit_err  = (i_wire_unit_state == UNIT_ERROR);

    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = 1'b0;
        rsp_valid_d   = 1'b0;
        rsp_status_d  = rsp_status_q;
        rsp_data_d    = rsp_data_q;
        unit_resetn_d = unit_resetn_q;
        unit_opcode_d = unit_opcode_q;
        cnt_load      = 1'b0;
        cnt_load_val  = '0;
        cnt_dec       = 1'b0;

        unique case (state_q)
            ST_REARM: begin
                unit_opcode_d = '0;
                if (cnt_term) begin
                    state_d       = ST_IDLE;
                    cmd_ready_d   = 1'b1;
                    unit_resetn_d = 1'b1;
                end else begin
                    cnt_dec       = 1'b1;
                    // release the unit one cycle ahead of cmd_ready
                    unit_resetn_d = (cnt_count == CW'(1));
                end
            end
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (i_wire_cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    if (i_wire_cmd_opcode == OP_RESET) begin
                        state_d      = ST_RESP;
                        rsp_valid_d  = 1'b1;
                        rsp_status_d = RSP_BADOP;
                        rsp_data_d   = '0;
                    end else begin
                        state_d       = ST_ISSUE;
                        unit_opcode_d = i_wire_cmd_opcode;
                        cnt_load      = 1'b1;
                        cnt_load_val  = TO_LOAD;
                    end
                end
            end
            ST_ISSUE, ST_WAIT: begin
                if (unit_done) begin
                    state_d       = ST_RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_status_d  = RSP_OK;
                    rsp_data_d    = i_wire_unit_return;
                    unit_opcode_d = '0;
                end else if (unit_err) begin
                    state_d       = ST_RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_status_d  = RSP_UNIT_ERROR;
                    rsp_data_d    = '0;
                    unit_opcode_d = '0;
                end else if (cnt_term) begin
                    state_d       = ST_RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_status_d  = RSP_TIMEOUT;
                    rsp_data_d    = '0;
                    unit_opcode_d = '0;
                end else begin
                    cnt_dec = 1'b1;
                    if ((state_q == ST_ISSUE) &&
                        (i_wire_unit_state != UNIT_IDLE)) begin
                        state_d       = ST_WAIT;
                        unit_opcode_d = '0;
                    end
                end
            end
            ST_RESP: begin
                rsp_valid_d = 1'b1;
                if (i_wire_rsp_ready) begin
                    state_d       = ST_REARM;
                    rsp_valid_d   = 1'b0;
                    rsp_status_d  = RSP_OK;
                    rsp_data_d    = '0;
                    unit_resetn_d = 1'b0;
                    cnt_load      = 1'b1;
                    cnt_load_val  = RA_LOAD;
                end
            end
            default: begin
                state_d       = ST_REARM;
                unit_resetn_d = 1'b0;
                unit_opcode_d = '0;
                cnt_load      = 1'b1;
                cnt_load_val  = RA_LOAD;
            end
        endcase
    end

    always_ff @(posedge i_wire_clock) begin
        if (!i_wire_resetn) begin
            state_q       <= ST_REARM;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_status_q  <= RSP_OK;
            rsp_data_q    <= '0;
            unit_resetn_q <= 1'b0;
            unit_opcode_q <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_status_q  <= rsp_status_d;
            rsp_data_q    <= rsp_data_d;
            unit_resetn_q <= unit_resetn_d;
            unit_opcode_q <= unit_opcode_d;
        end
    end

    assign o_wire_cmd_ready   = cmd_ready_q;
    assign o_wire_rsp_valid   = rsp_valid_q;
    assign o_wire_rsp_status  = rsp_status_q;
    assign o_wire_rsp_data    = rsp_data_q;
    assign o_wire_unit_resetn = unit_resetn_q;
    assign o_wire_unit_opcode = unit_opcode_q;

endmodule

// File: tb/tb_painterengine_gpu_gpuinfo_dispatch.sv
// Directed bench for the GPU info dispatcher with a small info-unit model
// and an override stub for timeout / mid-operation reset scenarios.
module tb_painterengine_gpu_gpuinfo_dispatch;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_opcode;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_status;
    logic [31:0] rsp_data;
    logic        unit_resetn;
    logic [31:0] unit_opcode;
    logic [31:0] unit_state;
    logic [31:0] unit_return;

    logic [31:0] m_state = 32'd0;
    logic [31:0] m_ret   = 32'd0;
    logic [31:0] m_op    = 32'd0;

    logic        stub_en;
    logic [31:0] stub_state;
    logic [31:0] stub_ret;

    int n_checks = 0;
    int n_err    = 0;
    int lat;

    always #5 clk = ~clk;

    painterengine_gpu_gpuinfo_dispatch dut (
        .i_wire_clock       (clk),
        .i_wire_resetn      (resetn),
        .i_wire_cmd_valid   (cmd_valid),
        .o_wire_cmd_ready   (cmd_ready),
        .i_wire_cmd_opcode  (cmd_opcode),
        .o_wire_rsp_valid   (rsp_valid),
        .i_wire_rsp_ready   (rsp_ready),
        .o_wire_rsp_status  (rsp_status),
        .o_wire_rsp_data    (rsp_data),
        .o_wire_unit_resetn (unit_resetn),
        .o_wire_unit_opcode (unit_opcode),
        .i_wire_unit_state  (unit_state),
        .i_wire_unit_return (unit_return)
    );

    // info unit: IDLE -> PROCESSING -> DONE/ERROR, held until reset
    always @(posedge clk) begin
        if (!unit_resetn) begin
            m_state <= 32'd0;
            m_ret   <= 32'd0;
        end else begin
            case (m_state)
                32'd0: begin
                    if (unit_opcode != 32'd0) begin
                        m_state <= 32'd1;
                        m_op    <= unit_opcode;
                    end
                end
                32'd1: begin
                    if (m_op == 32'd1) begin
                        m_state <= 32'd3;
                        m_ret   <= 32'h0000_0001;
                    end else if (m_op == 32'd2) begin
                        m_state <= 32'd3;
                        m_ret   <= 32'h2024_0612;
                    end else begin
                        m_state <= 32'd2;
                    end
                end
                default: ;
            endcase
        end
    end

    assign unit_state  = stub_en ? stub_state : m_state;
    assign unit_return = stub_en ? stub_ret   : m_ret;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] op);
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        tick();
        cmd_valid  = 1'b0;
        cmd_opcode = 32'd0;
    endtask

    // edges after the handshake edge until rsp_valid is seen
    task automatic wait_rsp(output int k);
        k = 0;
        while (!rsp_valid && k < 40) begin
            tick();
            k++;
        end
    endtask

    task automatic finish_rsp(input string tag, input bit chk_unit);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, "_r0_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_r0_uresetn"}, 32'(unit_resetn), 32'd0);
        check({tag, "_r0_ready"}, 32'(cmd_ready), 32'd0);
        tick();
        check({tag, "_r1_uresetn"}, 32'(unit_resetn), 32'd0);
        if (chk_unit) check({tag, "_unit_rearmed"}, m_state, 32'd0);
        tick();
        check({tag, "_r2_uresetn"}, 32'(unit_resetn), 32'd1);
        check({tag, "_r2_ready"}, 32'(cmd_ready), 32'd0);
        tick();
        check({tag, "_r3_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        bit stable;
        bit saw_rsp;
        bit saw_ready;

        resetn     = 1'b0;
        cmd_valid  = 1'b0;
        cmd_opcode = 32'd0;
        rsp_ready  = 1'b0;
        stub_en    = 1'b0;
        stub_state = 32'd0;
        stub_ret   = 32'd0;

        tick();
        tick();
        check("rst_ready", 32'(cmd_ready), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_status", 32'(rsp_status), 32'd0);
        check("rst_data", rsp_data, 32'd0);
        check("rst_uresetn", 32'(unit_resetn), 32'd0);
        check("rst_uop", unit_opcode, 32'd0);

        resetn = 1'b1;
        tick();
        check("init_p1_uresetn", 32'(unit_resetn), 32'd0);
        tick();
        check("init_p2_uresetn", 32'(unit_resetn), 32'd1);
        check("init_p2_ready", 32'(cmd_ready), 32'd0);
        tick();
        check("init_p3_ready", 32'(cmd_ready), 32'd1);

        // GETVERSION with explicit per-edge timing
        issue(32'd1);
        check("gv_e0_uop", unit_opcode, 32'd1);
        check("gv_e0_ready", 32'(cmd_ready), 32'd0);
        tick();
        check("gv_e1_valid", 32'(rsp_valid), 32'd0);
        tick();
        check("gv_e2_uop", unit_opcode, 32'd0);
        check("gv_e2_valid", 32'(rsp_valid), 32'd0);
        tick();
        check("gv_e3_valid", 32'(rsp_valid), 32'd1);
        check("gv_status", 32'(rsp_status), 32'd0);
        check("gv_data", rsp_data, 32'h0000_0001);
        check("gv_ready_busy", 32'(cmd_ready), 32'd0);
        finish_rsp("gv", 1'b1);

        // GETDEBUG
        issue(32'd2);
        wait_rsp(lat);
        check("gd_lat", 32'(lat), 32'd3);
        check("gd_status", 32'(rsp_status), 32'd0);
        check("gd_data", rsp_data, 32'h2024_0612);
        finish_rsp("gd", 1'b1);

        // unknown opcode -> unit ERROR
        issue(32'd5);
        wait_rsp(lat);
        check("unk_lat", 32'(lat), 32'd3);
        check("unk_status", 32'(rsp_status), 32'd1);
        check("unk_data", rsp_data, 32'd0);
        check("unk_unit_err", m_state, 32'd2);
        finish_rsp("unk", 1'b1);

        // BADOP
        issue(32'd0);
        check("bad_valid", 32'(rsp_valid), 32'd1);
        check("bad_status", 32'(rsp_status), 32'd3);
        check("bad_data", rsp_data, 32'd0);
        check("bad_uop", unit_opcode, 32'd0);
        check("bad_ready", 32'(cmd_ready), 32'd0);
        check("bad_unit_idle", m_state, 32'd0);
        finish_rsp("bad", 1'b0);
        check("bad_uop_after", unit_opcode, 32'd0);

        // timeout with unit stuck busy
        stub_en    = 1'b1;
        stub_state = 32'd1;
        stub_ret   = 32'h0000_BEEF;
        issue(32'd1);
        wait_rsp(lat);
        check("to_lat", 32'(lat), 32'd16);
        check("to_status", 32'(rsp_status), 32'd2);
        check("to_data", rsp_data, 32'd0);
        finish_rsp("to", 1'b0);

        // completion on the timeout cycle wins
        issue(32'd1);
        for (int i = 0; i < 15; i++) tick();
        check("tw_e15_valid", 32'(rsp_valid), 32'd0);
        stub_state = 32'd3;
        tick();
        check("tw_e16_valid", 32'(rsp_valid), 32'd1);
        check("tw_status", 32'(rsp_status), 32'd0);
        check("tw_data", rsp_data, 32'h0000_BEEF);
        finish_rsp("tw", 1'b0);
        stub_en    = 1'b0;
        stub_state = 32'd0;

        // backpressure
        issue(32'd2);
        wait_rsp(lat);
        check("bp_lat", 32'(lat), 32'd3);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!rsp_valid || rsp_status != 2'd0 ||
                rsp_data != 32'h2024_0612 || cmd_ready)
                stable = 1'b0;
        end
        check("bp_stable", 32'(stable), 32'd1);
        check("bp_data", rsp_data, 32'h2024_0612);
        finish_rsp("bp", 1'b1);

        // reset while in WAIT
        stub_en    = 1'b1;
        stub_state = 32'd1;
        issue(32'd1);
        tick();
        tick();
        tick();
        check("mr_uop_wait", unit_opcode, 32'd0);
        check("mr_uresetn_pre", 32'(unit_resetn), 32'd1);
        resetn = 1'b0;
        tick();
        check("mr_ready", 32'(cmd_ready), 32'd0);
        check("mr_valid", 32'(rsp_valid), 32'd0);
        check("mr_status", 32'(rsp_status), 32'd0);
        check("mr_data", rsp_data, 32'd0);
        check("mr_uresetn", 32'(unit_resetn), 32'd0);
        check("mr_uop", unit_opcode, 32'd0);
        stub_state = 32'd3;
        resetn = 1'b1;
        saw_rsp   = 1'b0;
        saw_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (rsp_valid) saw_rsp = 1'b1;
            if (cmd_ready) saw_ready = 1'b1;
        end
        check("mr_no_rsp", 32'(saw_rsp), 32'd0);
        check("mr_ready_back", 32'(saw_ready), 32'd1);
        stub_en    = 1'b0;
        stub_state = 32'd0;

        // sanity after recovery
        issue(32'd1);
        wait_rsp(lat);
        check("post_lat", 32'(lat), 32'd3);
        check("post_status", 32'(rsp_status), 32'd0);
        check("post_data", rsp_data, 32'h0000_0001);
        finish_rsp("post", 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
